load_store_unit: RTL and testbench

- Initiator side of the byte-addressed data-memory interface (addr / data_in / we / size / data_out).
- Accepts one load or store request at a time from the execute stage via a valid/ready handshake.
- Translates RISC-V funct3 into a memory access, drives the memory port with a single-cycle write strobe, and waits a programmable number of cycles.
- Returns sign- or zero-extended load data, or a store acknowledge, on a valid/ready response channel.

---
 rtl/load_store_unit.sv | 184 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: takes one RISC-V load or store at a time, performs a single
// big-endian access on the data-memory port and returns an extended result.
module load_store_unit #(
   parameter int unsigned MEM_BYTES = 8,
   parameter int unsigned LATENCY   = 0
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_data_in,
   output logic        mem_we,
   output logic [1:0]  mem_size,
   input  logic [31:0] mem_data_out,
   output logic [1:0]  dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // the requester holds req_* stable until then, resp_* is held until taken.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_WAIT   = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   function automatic logic [1:0] size_of(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   size_of = 2'd0;
         2'b01:   size_of = 2'd1;
         default: size_of = 2'd3;
      endcase
   endfunction

   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
      case (f3)
         3'b000:  extend = {{24{d[7]}}, d[7:0]};
         3'b100:  extend = {24'd0, d[7:0]};
         3'b001:  extend = {{16{d[15]}}, d[15:0]};
         3'b101:  extend = {16'd0, d[15:0]};
         default: extend = d;
      endcase
   endfunction

   state_t      state_q, state_d;
   logic        write_q, write_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        req_ready_q, req_ready_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_error_q, resp_error_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_data_in_q, mem_data_in_d;
   logic        mem_we_q, mem_we_d;
   logic [1:0]  mem_size_q, mem_size_d;

   logic [1:0]  req_size;
   logic [32:0] req_end;
   logic        req_err;

   // One bit wider than the address so an access that wraps past 2^32 fails.
   always_comb begin
      req_size = size_of(req_funct3);
      req_end  = {1'b0, req_addr} + {31'd0, req_size} + 33'd1;
      req_err  = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                 (req_write && req_funct3[2]) || (req_end > 33'(MEM_BYTES));
   end

   always_comb begin
      state_d       = state_q;
      write_d       = write_q;
      funct3_d      = funct3_q;
      cnt_d         = cnt_q;
      req_ready_d   = req_ready_q;
      resp_valid_d  = resp_valid_q;
      resp_rdata_d  = resp_rdata_q;
      resp_error_d  = resp_error_q;
      mem_addr_d    = mem_addr_q;
      mem_data_in_d = mem_data_in_q;
      mem_we_d      = mem_we_q;
      mem_size_d    = mem_size_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               req_ready_d = 1'b0;
               write_d     = req_write;
               funct3_d    = req_funct3;
               if (req_err) begin
                  resp_valid_d = 1'b1;
                  resp_error_d = 1'b1;
                  resp_rdata_d = 32'd0;
                  state_d      = S_RESP;
               end else begin
                  mem_addr_d    = req_addr;
                  mem_size_d    = req_size;
                  mem_data_in_d = req_wdata;
                  mem_we_d      = req_write;
                  state_d       = S_ACCESS;
               end
            end
         end
         S_ACCESS: begin
            mem_we_d = 1'b0;
            if (LATENCY == 0) begin
               resp_rdata_d = write_q ? 32'd0 : extend(funct3_q, mem_data_out);
               resp_valid_d = 1'b1;
               state_d      = S_RESP;
            end else begin
               cnt_d   = 4'(LATENCY);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q <= 4'd1) begin
               resp_rdata_d = write_q ? 32'd0 : extend(funct3_q, mem_data_out);
               resp_valid_d = 1'b1;
               state_d      = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               resp_rdata_d = 32'd0;
               resp_error_d = 1'b0;
               req_ready_d  = 1'b1;
               state_d      = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         write_q       <= 1'b0;
         funct3_q      <= 3'd0;
         cnt_q         <= 4'd0;
         req_ready_q   <= 1'b1;
         resp_valid_q  <= 1'b0;
         resp_rdata_q  <= 32'd0;
         resp_error_q  <= 1'b0;
         mem_addr_q    <= 32'd0;
         mem_data_in_q <= 32'd0;
         mem_we_q      <= 1'b0;
         mem_size_q    <= 2'd0;
      end else begin
         state_q       <= state_d;
         write_q       <= write_d;
         funct3_q      <= funct3_d;
         cnt_q         <= cnt_d;
         req_ready_q   <= req_ready_d;
         resp_valid_q  <= resp_valid_d;
         resp_rdata_q  <= resp_rdata_d;
         resp_error_q  <= resp_error_d;
         mem_addr_q    <= mem_addr_d;
         mem_data_in_q <= mem_data_in_d;
         mem_we_q      <= mem_we_d;
         mem_size_q    <= mem_size_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign resp_valid  = resp_valid_q;
   assign resp_rdata  = resp_rdata_q;
   assign resp_error  = resp_error_q;
   assign mem_addr    = mem_addr_q;
   assign mem_data_in = mem_data_in_q;
   assign mem_we      = mem_we_q;
   assign mem_size    = mem_size_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: instance 0 has LATENCY=0, instance 1 LATENCY=2,
// each attached to its own 8-byte big-endian memory.
module tb_load_store_unit;

   logic        clock;
   logic        reset_n;
   logic        req_valid[2];
   logic        req_ready[2];
   logic        req_write[2];
   logic [2:0]  req_funct3[2];
   logic [31:0] req_addr[2];
   logic [31:0] req_wdata[2];
   logic        resp_valid[2];
   logic        resp_ready[2];
   logic [31:0] resp_rdata[2];
   logic        resp_error[2];
   logic [31:0] mem_addr[2];
   logic [31:0] mem_data_in[2];
   logic        mem_we[2];
   logic [1:0]  mem_size[2];
   logic [31:0] mem_data_out[2];
   logic [1:0]  dbg_state[2];

   logic [7:0]  mem[2][8];
   logic [7:0]  sb_mem[2][8];
   logic [32:0] exp_q[$];
   int          checks;
   int          errors;
   int          we_cnt[2];
   logic [31:0] we_addr[2];
   logic [31:0] we_data[2];
   logic [1:0]  we_size[2];
   logic [31:0] rd_a;

   load_store_unit #(.MEM_BYTES(8), .LATENCY(0)) u_dut_l0 (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
      .resp_error(resp_error[0]), .mem_addr(mem_addr[0]), .mem_data_in(mem_data_in[0]),
      .mem_we(mem_we[0]), .mem_size(mem_size[0]), .mem_data_out(mem_data_out[0]),
      .dbg_state(dbg_state[0])
   );

   load_store_unit #(.MEM_BYTES(8), .LATENCY(2)) u_dut_l2 (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
      .resp_error(resp_error[1]), .mem_addr(mem_addr[1]), .mem_data_in(mem_data_in[1]),
      .mem_we(mem_we[1]), .mem_size(mem_size[1]), .mem_data_out(mem_data_out[1]),
      .dbg_state(dbg_state[1])
   );

   // ---------------- clock ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- memories ----------------
   always_comb begin
      rd_a = 32'd0;
      for (int g = 0; g < 2; g++) begin
         mem_data_out[g] = 32'd0;
         for (int k = 0; k < 4; k++) begin
            if (k <= int'(mem_size[g])) begin
               rd_a = mem_addr[g] + 32'(k);
               if (rd_a < 32'd8)
                  mem_data_out[g][(int'(mem_size[g]) - k) * 8 +: 8] = mem[g][rd_a[2:0]];
            end
         end
      end
   end

   always @(posedge clock) begin
      for (int g = 0; g < 2; g++) begin
         if (mem_we[g]) begin
            for (int k = 0; k < 4; k++) begin
               if (k <= int'(mem_size[g]) && (mem_addr[g] + 32'(k)) < 32'd8)
                  mem[g][3'(mem_addr[g] + 32'(k))] <= mem_data_in[g][(int'(mem_size[g]) - k) * 8 +: 8];
            end
         end
      end
   end

   always @(negedge clock) begin
      for (int g = 0; g < 2; g++) begin
         if (mem_we[g]) begin
            we_cnt[g]  <= we_cnt[g] + 1;
            we_addr[g] <= mem_addr[g];
            we_data[g] <= mem_data_in[g];
            we_size[g] <= mem_size[g];
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic int nbytes(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] model_load(input int g, input logic [2:0] f3, input int addr);
      logic [31:0] raw;
      raw = 32'd0;
      for (int k = 0; k < nbytes(f3); k++) raw = (raw << 8) | {24'd0, sb_mem[g][addr + k]};
      case (f3)
         3'b000:  return {{24{raw[7]}}, raw[7:0]};
         3'b100:  return {24'd0, raw[7:0]};
         3'b001:  return {{16{raw[15]}}, raw[15:0]};
         3'b101:  return {16'd0, raw[15:0]};
         default: return raw;
      endcase
   endfunction

   function automatic void model_store(input int g, input logic [2:0] f3, input int addr,
                                       input logic [31:0] wdata);
      int nb;
      nb = nbytes(f3);
      for (int k = 0; k < nb; k++) sb_mem[g][addr + k] = wdata[(nb - 1 - k) * 8 +: 8];
   endfunction

   // ---------------- drivers ----------------
   task automatic drive_req(input int g, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata);
      int waited;
      @(negedge clock);
      req_write[g]  = wr;
      req_funct3[g] = f3;
      req_addr[g]   = addr;
      req_wdata[g]  = wdata;
      req_valid[g]  = 1'b1;
      waited = 0;
      while (!req_ready[g] && waited < 50) begin
         @(negedge clock);
         waited++;
      end
      @(posedge clock);
      #1 req_valid[g] = 1'b0;
   endtask

   task automatic wait_resp(input int g, input int hold, output logic [31:0] rd,
                            output logic er, output int n);
      n = 1;
      @(negedge clock);
      while (!resp_valid[g] && n < 60) begin
         @(negedge clock);
         n++;
      end
      rd = resp_rdata[g];
      er = resp_error[g];
      repeat (hold) @(negedge clock);
      resp_ready[g] = 1'b1;
      @(posedge clock);
      #1 resp_ready[g] = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #2 reset_n = 1'b0;
      #1;
      for (int g = 0; g < 2; g++) begin
         checks++;
         if (req_ready[g] !== 1'b1) begin
            errors++; $display("FAIL reset_req_ready dut%0d got %b exp 1", g, req_ready[g]);
         end
         checks++;
         if ({resp_valid[g], resp_error[g], mem_we[g]} !== 3'b000) begin
            errors++; $display("FAIL reset_flags dut%0d got %b exp 000", g, {resp_valid[g], resp_error[g], mem_we[g]});
         end
         checks++;
         if (resp_rdata[g] !== 32'd0) begin
            errors++; $display("FAIL reset_rdata dut%0d got %h exp 0", g, resp_rdata[g]);
         end
         checks++;
         if ({mem_addr[g], mem_data_in[g], mem_size[g]} !== 66'd0) begin
            errors++; $display("FAIL reset_mem_port dut%0d got %h %h %h exp 0", g, mem_addr[g], mem_data_in[g], mem_size[g]);
         end
         checks++;
         if (dbg_state[g] !== 2'd0) begin
            errors++; $display("FAIL reset_state dut%0d got %0d exp 0", g, dbg_state[g]);
         end
      end
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_store_word();
      logic [31:0] rd;
      logic        er;
      logic [32:0] exp;
      int          n, we0;
      we0 = we_cnt[0];
      model_store(0, 3'b010, 0, 32'hDEADBEEF);
      exp_q.push_back({1'b0, 32'd0});
      drive_req(0, 1'b1, 3'b010, 32'd0, 32'hDEADBEEF);
      wait_resp(0, 0, rd, er, n);
      exp = exp_q.pop_front();
      checks++;
      if ({er, rd} !== exp) begin
         errors++; $display("FAIL sw_resp got %h exp %h", {er, rd}, exp);
      end
      checks++;
      if (n != 2) begin
         errors++; $display("FAIL sw_latency got %0d exp 2", n);
      end
      checks++;
      if (we_cnt[0] - we0 != 1) begin
         errors++; $display("FAIL sw_we_cycles got %0d exp 1", we_cnt[0] - we0);
      end
      checks++;
      if ({we_addr[0], we_size[0], we_data[0]} !== {32'd0, 2'd3, 32'hDEADBEEF}) begin
         errors++; $display("FAIL sw_mem_port got %h %h %h exp 0 3 deadbeef", we_addr[0], we_size[0], we_data[0]);
      end
      exp_q.push_back({1'b0, 32'hDEADBEEF});
      drive_req(0, 1'b0, 3'b010, 32'd0, 32'd0);
      wait_resp(0, 0, rd, er, n);
      exp = exp_q.pop_front();
      checks++;
      if ({er, rd} !== exp) begin
         errors++; $display("FAIL lw_after_sw got %h exp %h", {er, rd}, exp);
      end
   endtask

   task automatic test_load_extend();
      logic [2:0]  f3s[4]  = '{3'b000, 3'b100, 3'b001, 3'b101};
      logic [31:0] adrs[4] = '{32'd1, 32'd1, 32'd2, 32'd2};
      logic [31:0] want[4] = '{32'hFFFFFFAD, 32'h000000AD, 32'hFFFFBEEF, 32'h0000BEEF};
      logic [31:0] rd;
      logic        er;
      logic [32:0] exp;
      int          n;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({1'b0, want[i]});
         drive_req(0, 1'b0, f3s[i], adrs[i], 32'd0);
         wait_resp(0, 0, rd, er, n);
         exp = exp_q.pop_front();
         checks++;
         if ({er, rd} !== exp) begin
            errors++; $display("FAIL load_ext_%0d got %h exp %h", i, {er, rd}, exp);
         end
      end
   endtask

   task automatic test_errors();
      logic        wrs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [2:0]  f3s[6]  = '{3'b010, 3'b011, 3'b100, 3'b000, 3'b001, 3'b110};
      logic [31:0] adrs[6] = '{32'd6, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd7, 32'd0};
      logic [31:0] rd;
      logic        er;
      logic [32:0] exp;
      int          n, we0;
      we0 = we_cnt[0];
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back({1'b1, 32'd0});
         drive_req(0, wrs[i], f3s[i], adrs[i], 32'hA5A5A5A5);
         wait_resp(0, 0, rd, er, n);
         exp = exp_q.pop_front();
         checks++;
         if ({er, rd} !== exp) begin
            errors++; $display("FAIL error_case_%0d got %h exp %h", i, {er, rd}, exp);
         end
      end
      checks++;
      if (we_cnt[0] != we0) begin
         errors++; $display("FAIL error_no_we got %0d exp %0d", we_cnt[0], we0);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd, r0;
      logic        er;
      logic [32:0] exp;
      int          n;
      exp_q.push_back({1'b0, model_load(0, 3'b010, 0)});
      drive_req(0, 1'b0, 3'b010, 32'd0, 32'd0);
      n = 1;
      @(negedge clock);
      while (!resp_valid[0] && n < 60) begin
         @(negedge clock);
         n++;
      end
      r0 = resp_rdata[0];
      er = resp_error[0];
      for (int i = 0; i < 3; i++) begin
         if (i == 0) begin
            req_write[0]  = 1'b0;
            req_funct3[0] = 3'b100;
            req_addr[0]   = 32'd3;
            req_valid[0]  = 1'b1;
         end
         checks++;
         if ({resp_valid[0], req_ready[0], resp_rdata[0]} !== {1'b1, 1'b0, r0}) begin
            errors++; $display("FAIL bp_hold_%0d got %b %b %h exp 1 0 %h", i, resp_valid[0], req_ready[0], resp_rdata[0], r0);
         end
         @(negedge clock);
      end
      resp_ready[0] = 1'b1;
      @(posedge clock);
      #1 resp_ready[0] = 1'b0;
      exp = exp_q.pop_front();
      checks++;
      if ({er, r0} !== exp) begin
         errors++; $display("FAIL bp_first_resp got %h exp %h", {er, r0}, exp);
      end
      exp_q.push_back({1'b0, model_load(0, 3'b100, 3)});
      @(negedge clock);
      checks++;
      if ({req_ready[0], resp_valid[0]} !== 2'b10) begin
         errors++; $display("FAIL bp_after_handshake got %b exp 10", {req_ready[0], resp_valid[0]});
      end
      @(posedge clock);
      #1 req_valid[0] = 1'b0;
      @(negedge clock);
      checks++;
      if (req_ready[0] !== 1'b0) begin
         errors++; $display("FAIL bp_second_accept got %b exp 0", req_ready[0]);
      end
      wait_resp(0, 0, rd, er, n);
      exp = exp_q.pop_front();
      checks++;
      if ({er, rd} !== exp) begin
         errors++; $display("FAIL bp_second_resp got %h exp %h", {er, rd}, exp);
      end
   endtask

   task automatic test_random();
      logic [2:0]  ld_f3[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      logic [2:0]  f3;
      logic [31:0] wdata, rd;
      logic        wr, er;
      logic [32:0] exp;
      int          n, addr;
      wdata = $urandom;
      model_store(0, 3'b010, 4, wdata);
      exp_q.push_back({1'b0, 32'd0});
      drive_req(0, 1'b1, 3'b010, 32'd4, wdata);
      wait_resp(0, 0, rd, er, n);
      exp = exp_q.pop_front();
      checks++;
      if ({er, rd} !== exp) begin
         errors++; $display("FAIL rand_init_store got %h exp %h", {er, rd}, exp);
      end
      for (int i = 0; i < 16; i++) begin
         wr    = ($urandom_range(0, 3) == 0);
         f3    = wr ? ld_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
         addr  = $urandom_range(0, 8 - nbytes(f3));
         wdata = $urandom;
         if (wr) begin
            model_store(0, f3, addr, wdata);
            exp_q.push_back({1'b0, 32'd0});
         end else begin
            exp_q.push_back({1'b0, model_load(0, f3, addr)});
         end
         drive_req(0, wr, f3, 32'(addr), wdata);
         wait_resp(0, $urandom_range(0, 2), rd, er, n);
         exp = exp_q.pop_front();
         checks++;
         if ({er, rd} !== exp) begin
            errors++; $display("FAIL rand_%0d wr=%b f3=%b addr=%0d got %h exp %h", i, wr, f3, addr, {er, rd}, exp);
         end
      end
   endtask

   task automatic run_latency2(input logic wr, input logic [2:0] f3, input int addr,
                               input logic [31:0] wdata);
      logic [31:0] rd;
      logic        er;
      logic [32:0] exp;
      int          n;
      if (wr) begin
         model_store(1, f3, addr, wdata);
         exp_q.push_back({1'b0, 32'd0});
      end else begin
         exp_q.push_back({1'b0, model_load(1, f3, addr)});
      end
      drive_req(1, wr, f3, 32'(addr), wdata);
      n = 1;
      @(negedge clock);
      while (!resp_valid[1] && n < 60) begin
         checks++;
         if ({mem_we[1], mem_addr[1]} !== {wr && (n == 1), 32'(addr)}) begin
            errors++; $display("FAIL l2_port_cycle%0d got we=%b addr=%h exp we=%b addr=%h", n, mem_we[1], mem_addr[1], wr && (n == 1), addr);
         end
         @(negedge clock);
         n++;
      end
      checks++;
      if (n != 4) begin
         errors++; $display("FAIL l2_latency got %0d exp 4", n);
      end
      rd = resp_rdata[1];
      er = resp_error[1];
      resp_ready[1] = 1'b1;
      @(posedge clock);
      #1 resp_ready[1] = 1'b0;
      exp = exp_q.pop_front();
      checks++;
      if ({er, rd} !== exp) begin
         errors++; $display("FAIL l2_resp got %h exp %h", {er, rd}, exp);
      end
   endtask

   task automatic test_latency2();
      int we0;
      we0 = we_cnt[1];
      run_latency2(1'b1, 3'b010, 4, 32'h12345678);
      checks++;
      if (we_cnt[1] - we0 != 1) begin
         errors++; $display("FAIL l2_we_cycles got %0d exp 1", we_cnt[1] - we0);
      end
      run_latency2(1'b0, 3'b010, 4, 32'd0);
      run_latency2(1'b0, 3'b001, 6, 32'd0);
      run_latency2(1'b0, 3'b000, 5, 32'd0);
   endtask

   task automatic test_reset_mid_wait();
      logic [31:0] rd;
      logic        er;
      logic [32:0] exp;
      int          n;
      model_store(1, 3'b010, 4, 32'hCAFEF00D);
      drive_req(1, 1'b1, 3'b010, 32'd4, 32'hCAFEF00D);
      @(negedge clock);
      @(negedge clock);
      checks++;
      if (mem_addr[1] !== 32'd4) begin
         errors++; $display("FAIL rst_pre_addr got %h exp 4", mem_addr[1]);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({mem_we[1], resp_valid[1], mem_addr[1], mem_size[1], mem_data_in[1]} !== 68'd0) begin
         errors++; $display("FAIL rst_async got we=%b rv=%b addr=%h size=%h din=%h exp 0", mem_we[1], resp_valid[1], mem_addr[1], mem_size[1], mem_data_in[1]);
      end
      checks++;
      if (req_ready[1] !== 1'b1) begin
         errors++; $display("FAIL rst_async_ready got %b exp 1", req_ready[1]);
      end
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         checks++;
         if ({resp_valid[1], req_ready[1]} !== 2'b01) begin
            errors++; $display("FAIL rst_no_stale_%0d got %b exp 01", i, {resp_valid[1], req_ready[1]});
         end
      end
      exp_q.push_back({1'b0, model_load(1, 3'b010, 4)});
      drive_req(1, 1'b0, 3'b010, 32'd4, 32'd0);
      wait_resp(1, 0, rd, er, n);
      exp = exp_q.pop_front();
      checks++;
      if ({er, rd} !== exp) begin
         errors++; $display("FAIL rst_followup got %h exp %h", {er, rd}, exp);
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      reset_n = 1'b1;
      for (int g = 0; g < 2; g++) begin
         req_valid[g]  = 1'b0;
         req_write[g]  = 1'b0;
         req_funct3[g] = 3'd0;
         req_addr[g]   = 32'd0;
         req_wdata[g]  = 32'd0;
         resp_ready[g] = 1'b0;
      end
      test_reset();
      test_store_word();
      test_load_extend();
      test_errors();
      test_backpressure();
      test_random();
      test_latency2();
      test_reset_mid_wait();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
